// File: rtl/bin_frame_scheduler.sv
// bin_frame_scheduler
//   Takes 16 spectral bins from mic_translator and sends them to the column driver one column at
//   a time. Each new bin set lands in a pending bank. The pending bank is copied to the active
//   bank only at a frame boundary, so a displayed frame is never a mix of two bin sets. A
//   per-column peak-hold value, with programmable decay, travels alongside each level.
//
// Parameters
//   W          bin / level width
//   DECAY_DIV  number of loaded frames per 1-LSB peak decay (>= 1)
//
// Ports
//   clk        system clock
//   reset      synchronous, active-low reset
//   new_t      one-cycle strobe; t0..t15 are valid in the same cycle
//   t0..t15    unsigned bin magnitudes
//   col_valid  column transfer offered
//   col_ready  driver accepts the column
//   col_idx    column number 0..15
//   col_level  active-bank level for col_idx
//   col_peak   peak-hold value for col_idx
//   frame_done one-cycle pulse after column 15 is accepted
//   overrun    sticky; a pending frame was overwritten before it was loaded
module bin_frame_scheduler #(
    parameter int unsigned W         = 10,
    parameter int unsigned DECAY_DIV = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         new_t,
    input  logic [W-1:0] t0,
    input  logic [W-1:0] t1,
    input  logic [W-1:0] t2,
    input  logic [W-1:0] t3,
    input  logic [W-1:0] t4,
    input  logic [W-1:0] t5,
    input  logic [W-1:0] t6,
    input  logic [W-1:0] t7,
    input  logic [W-1:0] t8,
    input  logic [W-1:0] t9,
    input  logic [W-1:0] t10,
    input  logic [W-1:0] t11,
    input  logic [W-1:0] t12,
    input  logic [W-1:0] t13,
    input  logic [W-1:0] t14,
    input  logic [W-1:0] t15,
    output logic         col_valid,
    input  logic         col_ready,
    output logic [3:0]   col_idx,
    output logic [W-1:0] col_level,
    output logic [W-1:0] col_peak,
    output logic         frame_done,
    output logic         overrun
);

    // Keep the frame counter at least one bit wide so that DECAY_DIV = 1 still elaborates.
    localparam int unsigned FcW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [FcW-1:0] FcLast = FcW'(DECAY_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StScan, StWrap} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pend_bank_q [16];
    logic [W-1:0]   act_bank_q  [16];
    logic [W-1:0]   peak_bank_q [16];
    logic [W-1:0]   peak_next   [16];
    logic [W-1:0]   t_in        [16];
    logic           pend_q;
    logic           overrun_q;
    logic [FcW-1:0] fc_q;
    logic [3:0]     idx_q;
    logic           decay_now;

    assign t_in[0]  = t0;
    assign t_in[1]  = t1;
    assign t_in[2]  = t2;
    assign t_in[3]  = t3;
    assign t_in[4]  = t4;
    assign t_in[5]  = t5;
    assign t_in[6]  = t6;
    assign t_in[7]  = t7;
    assign t_in[8]  = t8;
    assign t_in[9]  = t9;
    assign t_in[10] = t10;
    assign t_in[11] = t11;
    assign t_in[12] = t12;
    assign t_in[13] = t13;
    assign t_in[14] = t14;
    assign t_in[15] = t15;

    assign decay_now = (fc_q == FcLast);

    // Peak candidate: the (possibly decayed) held peak against the incoming level.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] held;
            held = peak_bank_q[i];
            if (decay_now && (held != '0)) begin
                held = held - 1'b1;
            end
            peak_next[i] = (pend_bank_q[i] > held) ? pend_bank_q[i] : held;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pend_q) state_d = StLoad;
            StLoad: state_d = StScan;
            StScan: if (col_ready && (idx_q == 4'd15)) state_d = StWrap;
            // Going straight back to LOAD gives the 18-cycle back-to-back frame period.
            StWrap: state_d = pend_q ? StLoad : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            fc_q      <= '0;
            idx_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                pend_bank_q[i] <= '0;
                act_bank_q[i]  <= '0;
                peak_bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            // A strobe during LOAD keeps pend set; the loaded set was not lost, so no overrun.
            if (new_t) begin
                pend_bank_q <= t_in;
                pend_q      <= 1'b1;
                if (pend_q && (state_q != StLoad)) begin
                    overrun_q <= 1'b1;
                end
            end else if (state_q == StLoad) begin
                pend_q <= 1'b0;
            end

            if (state_q == StLoad) begin
                act_bank_q  <= pend_bank_q;
                peak_bank_q <= peak_next;
                fc_q        <= decay_now ? '0 : fc_q + 1'b1;
                idx_q       <= '0;
            end else if ((state_q == StScan) && col_ready && (idx_q != 4'd15)) begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    // Outputs decode from registers only; col_ready and new_t never reach them combinationally.
    assign col_valid  = (state_q == StScan);
    assign frame_done = (state_q == StWrap);
    assign col_idx    = idx_q;
    assign col_level  = act_bank_q[idx_q];
    assign col_peak   = peak_bank_q[idx_q];
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bin_frame_scheduler.sv
// Bench for bin_frame_scheduler: three instances (DECAY_DIV 8, 2, 1) share one stimulus stream.
// A frame-level reference model predicts every output each cycle.
module tb_bin_frame_scheduler;

    localparam int W = 10;
    localparam int NDUT = 3;

    // Model phases
    localparam int PhIdle = 0;
    localparam int PhLoad = 1;
    localparam int PhScan = 2;
    localparam int PhWrap = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_t;
    logic         col_ready;
    logic [W-1:0] t [16];

    logic         vld   [NDUT];
    logic         fdone [NDUT];
    logic         ovr   [NDUT];
    logic [3:0]   cidx  [NDUT];
    logic [W-1:0] clev  [NDUT];
    logic [W-1:0] cpk   [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bin_frame_scheduler #(
            .W         (W),
            .DECAY_DIV ((g == 0) ? 8 : ((g == 1) ? 2 : 1))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .new_t      (new_t),
            .t0         (t[0]),
            .t1         (t[1]),
            .t2         (t[2]),
            .t3         (t[3]),
            .t4         (t[4]),
            .t5         (t[5]),
            .t6         (t[6]),
            .t7         (t[7]),
            .t8         (t[8]),
            .t9         (t[9]),
            .t10        (t[10]),
            .t11        (t[11]),
            .t12        (t[12]),
            .t13        (t[13]),
            .t14        (t[14]),
            .t15        (t[15]),
            .col_valid  (vld[g]),
            .col_ready  (col_ready),
            .col_idx    (cidx[g]),
            .col_level  (clev[g]),
            .col_peak   (cpk[g]),
            .frame_done (fdone[g]),
            .overrun    (ovr[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_ph, m_col, m_loads;
    bit m_pend, m_ovr, m_in_reset;
    int m_p [16];
    int m_a [16];
    int m_k [NDUT][16];
    int tn  [16];

    function automatic int div_of(int g);
        return (g == 0) ? 8 : ((g == 1) ? 2 : 1);
    endfunction

    task automatic check(string tag, int unsigned obs, int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    endtask

    task automatic model_clear();
        m_ph = PhIdle; m_col = 0; m_loads = 0; m_pend = 0; m_ovr = 0;
        for (int i = 0; i < 16; i++) begin
            m_p[i] = 0; m_a[i] = 0;
            for (int g = 0; g < NDUT; g++) m_k[g][i] = 0;
        end
    endtask

    // Advance the model across one clock edge using the inputs now being driven.
    task automatic model_step();
        int nph;
        m_in_reset = !reset;
        if (!reset) begin
            model_clear();
            return;
        end
        nph = m_ph;
        case (m_ph)
            PhIdle: if (m_pend) nph = PhLoad;
            PhLoad: begin
                for (int i = 0; i < 16; i++) begin
                    m_a[i] = m_p[i];
                    for (int g = 0; g < NDUT; g++) begin
                        int held;
                        held = m_k[g][i];
                        if ((m_loads % div_of(g)) == div_of(g) - 1 && held > 0) held = held - 1;
                        m_k[g][i] = (m_p[i] > held) ? m_p[i] : held;
                    end
                end
                m_loads++;
                m_col = 0;
                nph = PhScan;
            end
            PhScan: if (col_ready) begin
                if (m_col == 15) nph = PhWrap;
                else m_col++;
            end
            default: nph = m_pend ? PhLoad : PhIdle;
        endcase
        if (new_t) begin
            if (m_pend && m_ph != PhLoad) m_ovr = 1;
            for (int i = 0; i < 16; i++) m_p[i] = int'(t[i]);
            m_pend = 1;
        end else if (m_ph == PhLoad) begin
            m_pend = 0;
        end
        m_ph = nph;
    endtask

    task automatic compare_all();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("col_valid[%0d]", g), vld[g], (m_ph == PhScan) ? 1 : 0);
            check($sformatf("frame_done[%0d]", g), fdone[g], (m_ph == PhWrap) ? 1 : 0);
            check($sformatf("overrun[%0d]", g), ovr[g], m_ovr);
            if (m_ph == PhScan || m_in_reset) begin
                check($sformatf("col_idx[%0d]", g), cidx[g], m_in_reset ? 0 : m_col);
                check($sformatf("col_level[%0d]", g), clev[g], m_in_reset ? 0 : m_a[m_col]);
                check($sformatf("col_peak[%0d]", g), cpk[g], m_in_reset ? 0 : m_k[g][m_col]);
            end
        end
    endtask

    // One cycle: check the current outputs, then drive this cycle's inputs and step the model.
    task automatic cycle(bit rst_n, bit nt, bit rdy);
        @(negedge clk);
        compare_all();
        reset     = rst_n;
        new_t     = nt;
        col_ready = rdy;
        for (int i = 0; i < 16; i++) t[i] = W'(tn[i]);
        model_step();
    endtask

    task automatic run(int n, bit rdy);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, rdy);
    endtask

    task automatic fill(int v);
        for (int i = 0; i < 16; i++) tn[i] = v;
    endtask

    task automatic frame(int v);
        fill(v);
        cycle(1'b1, 1'b1, 1'b1);
        run(22, 1'b1);
    endtask

    initial begin
        reset = 1'b0; new_t = 1'b0; col_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin t[i] = '0; tn[i] = 0; end
        model_clear();
        m_in_reset = 0;
        // First edge establishes reset; outputs are checked from the following cycle on.
        @(negedge clk);
        m_in_reset = 1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // Single frame, ramp data
        for (int i = 0; i < 16; i++) tn[i] = 16 * i;
        cycle(1'b1, 1'b1, 1'b1);
        run(24, 1'b1);

        // Backpressure: ready alternates, starting low
        for (int i = 0; i < 16; i++) tn[i] = int'($urandom_range(0, 1023));
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 45; k++) cycle(1'b1, 1'b0, k[0]);

        // Tear-free double buffering and overrun
        fill(100); cycle(1'b1, 1'b1, 1'b1);
        run(5, 1'b1);
        fill(200); cycle(1'b1, 1'b1, 1'b1);
        run(3, 1'b1);
        fill(300); cycle(1'b1, 1'b1, 1'b1);
        run(40, 1'b1);

        // Peak decay (checked on the DECAY_DIV = 2 instance)
        cycle(1'b0, 1'b0, 1'b1);
        frame(100); frame(50); frame(50); frame(50);

        // Peak floor (checked on the DECAY_DIV = 1 instance)
        cycle(1'b0, 1'b0, 1'b1);
        frame(1); frame(0); frame(0);

        // Reset mid-scan at column 7
        for (int i = 0; i < 16; i++) tn[i] = int'($urandom_range(0, 1023));
        cycle(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 40 && !(m_ph == PhScan && m_col == 7); k++) cycle(1'b1, 1'b0, 1'b1);
        check("reached_col7", (m_ph == PhScan && m_col == 7) ? 1 : 0, 1);
        cycle(1'b0, 1'b0, 1'b1);
        run(3, 1'b1);
        frame(5);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            bit rst_n, nt, rdy;
            rst_n = ($urandom_range(0, 599) != 0);
            nt    = ($urandom_range(0, 15) == 0);
            rdy   = ($urandom_range(0, 3) != 0);
            if (nt) for (int i = 0; i < 16; i++) tn[i] = int'($urandom_range(0, 1023));
            cycle(rst_n, nt, rdy);
        end
        cycle(1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
